// File: rtl/avmm_bridge_pkg.sv
// Shared definitions for the Avalon-MM slot bridge: FSM encoding, status
// register ids and the read data returned for unpopulated slots.
package avmm_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam int STAT_ERR     = 0;
  localparam int STAT_NSLOTS  = 1;
  localparam int STAT_TIMEOUT = 2;

  localparam logic [63:0] ERR_RDATA = '1;

endpackage

// File: rtl/avmm_slot_select.sv
// Combinational N_SLOTS-way read mux over the flattened slot_out bus,
// with a range check telling whether the slot id is populated.
module avmm_slot_select #(
  parameter int N_SLOTS = 4,
  parameter int MID_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic [MID_W-1:0]          mid,
  input  logic [N_SLOTS*DATA_W-1:0] slot_out,
  output logic [DATA_W-1:0]         data,
  output logic                      valid
);

  always_comb begin
    data = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (mid == MID_W'(k)) data = slot_out[k*DATA_W +: DATA_W];
    end
  end

  assign valid = (int'(mid) < N_SLOTS);

endmodule

// File: rtl/avmm_slot_bridge.sv
// Avalon-MM slave front end: decodes {mid, vid}, strobes the selected slot,
// waits on its busy flag with a timeout, and serves a status bank at mid = all-ones.
module avmm_slot_bridge
  import avmm_bridge_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int MID_W   = 3,
  parameter int VID_W   = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               s0_address,
  input  logic                      s0_read,
  input  logic                      s0_write,
  input  logic [DATA_W-1:0]         s0_writedata,
  output logic [DATA_W-1:0]         s0_readdata,
  output logic                      s0_waitrequest,
  output logic [N_SLOTS-1:0]        slot_strobe,
  output logic [VID_W-1:0]          slot_vid,
  output logic [DATA_W-1:0]         slot_in,
  input  logic [N_SLOTS*DATA_W-1:0] slot_out,
  input  logic [N_SLOTS-1:0]        slot_wait
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [MID_W-1:0] STAT_MID = '1;

  state_t              state_reg, state_next;
  logic [MID_W-1:0]    mid_reg;
  logic [VID_W-1:0]    vid_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   readdata_reg;
  logic                waitrequest_reg;
  logic [15:0]         err_count_reg;
  logic [MID_W-1:0]    last_err_mid_reg;
  logic                sticky_err_reg;

  logic [MID_W-1:0]    addr_mid, sel_mid, err_mid;
  logic [VID_W-1:0]    addr_vid;
  logic                req, sel_valid, wait_sel, log_err;
  logic [DATA_W-1:0]   sel_data, status_word;
  logic [N_SLOTS-1:0]  mid_onehot;

  assign addr_mid = s0_address[MID_W+VID_W-1:VID_W];
  assign addr_vid = s0_address[VID_W-1:0];
  assign req      = s0_read | s0_write;

  generate
    if (MID_W + VID_W < 16) begin : g_spare_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^s0_address[15:MID_W+VID_W];
    end
  endgenerate

  // Decode from the live address while idle, from the latched id afterwards.
  assign sel_mid = (state_reg == ST_IDLE) ? addr_mid : mid_reg;

  avmm_slot_select #(
    .N_SLOTS (N_SLOTS),
    .MID_W   (MID_W),
    .DATA_W  (DATA_W)
  ) u_select (
    .mid      (sel_mid),
    .slot_out (slot_out),
    .data     (sel_data),
    .valid    (sel_valid)
  );

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_onehot
      assign mid_onehot[gi] = (mid_reg == MID_W'(gi));
    end
  endgenerate

  assign wait_sel = |(slot_wait & mid_onehot);

  always_comb begin
    status_word = '0;
    if (addr_vid == VID_W'(STAT_ERR))
      status_word = DATA_W'({err_count_reg, 8'(last_err_mid_reg), 7'b0, sticky_err_reg});
    else if (addr_vid == VID_W'(STAT_NSLOTS))
      status_word = DATA_W'(N_SLOTS);
    else if (addr_vid == VID_W'(STAT_TIMEOUT))
      status_word = DATA_W'(TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    log_err    = 1'b0;
    err_mid    = mid_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (addr_mid == STAT_MID) begin
            state_next = ST_RESP;
          end else if (!sel_valid) begin
            state_next = ST_RESP;
            log_err    = 1'b1;
            err_mid    = addr_mid;
          end else if (s0_write) begin
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_SAMPLE;
          end
        end
      end
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (!wait_sel) begin
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next = ST_RESP;
          log_err    = 1'b1;
        end
      end
      ST_SAMPLE: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_strobe    = (state_reg == ST_ISSUE) ? mid_onehot : '0;
    slot_vid       = vid_reg;
    slot_in        = wdata_reg;
    s0_readdata    = readdata_reg;
    s0_waitrequest = waitrequest_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mid_reg          <= '0;
      vid_reg          <= '0;
      wdata_reg        <= '0;
      cnt_reg          <= '0;
      readdata_reg     <= '0;
      waitrequest_reg  <= 1'b1;
      err_count_reg    <= '0;
      last_err_mid_reg <= '0;
      sticky_err_reg   <= 1'b0;
    end else begin
      waitrequest_reg <= (state_next != ST_RESP);

      if (state_reg == ST_IDLE && req) begin
        mid_reg   <= addr_mid;
        vid_reg   <= addr_vid;
        wdata_reg <= s0_writedata;
        if (!s0_write) begin
          if (addr_mid == STAT_MID)  readdata_reg <= status_word;
          else if (!sel_valid)       readdata_reg <= DATA_W'(ERR_RDATA);
        end
      end

      if (state_reg == ST_SAMPLE) readdata_reg <= sel_data;

      if (state_reg == ST_ISSUE)                cnt_reg <= '0;
      else if (state_reg == ST_WAIT && wait_sel) cnt_reg <= cnt_reg + CNT_W'(1);

      if (log_err) begin
        if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
        last_err_mid_reg <= err_mid;
        sticky_err_reg   <= 1'b1;
      end else if (state_reg == ST_IDLE && s0_write && addr_mid == STAT_MID &&
                   addr_vid == VID_W'(STAT_ERR)) begin
        err_count_reg    <= '0;
        last_err_mid_reg <= '0;
        sticky_err_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_slot_bridge.sv
// Directed plus randomized bench for avmm_slot_bridge against a
// transaction-level model of latency, strobes, read data and error status.
module tb_avmm_slot_bridge;

  localparam int TOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  s0_address;
  logic         s0_read, s0_write;
  logic [31:0]  s0_writedata, s0_readdata;
  logic         s0_waitrequest;
  logic [3:0]   slot_strobe;
  logic [11:0]  slot_vid;
  logic [31:0]  slot_in;
  logic [127:0] slot_out;
  logic [3:0]   slot_wait;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] so_model [4];
  int          m_err;
  logic [2:0]  m_last;
  logic        m_sticky;

  avmm_slot_bridge #(
    .N_SLOTS(4), .MID_W(3), .VID_W(12), .DATA_W(32), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .s0_address(s0_address), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
    .s0_waitrequest(s0_waitrequest), .slot_strobe(slot_strobe), .slot_vid(slot_vid),
    .slot_in(slot_in), .slot_out(slot_out), .slot_wait(slot_wait)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_slots(input bit rnd);
    for (int k = 0; k < 4; k++) begin
      if (rnd) so_model[k] = $urandom;
      slot_out[k*32 +: 32] = so_model[k];
    end
  endtask

  task automatic model_log(input logic [2:0] mid);
    if (m_err < 65535) m_err++;
    m_last   = mid;
    m_sticky = 1'b1;
  endtask

  // One complete bus transaction; the slot holds its busy flag for `stall`
  // cycles after the strobe (stall >= TOUT means it never releases).
  task automatic run_txn(input string tag, input bit wr, input bit rd, input logic [2:0] mid,
                         input logic [11:0] vid, input logic [31:0] wd, input int stall);
    int          exp_lat, exp_stb, lat, nstb, sc;
    bit          chk_rd;
    logic [31:0] exp_rd, got_rd;
    exp_rd = '0;
    chk_rd = 1'b0;
    exp_stb = 0;
    if (mid == 3'd7) begin
      exp_lat = 1;
      if (wr) begin
        if (vid == 12'd0) begin m_err = 0; m_last = '0; m_sticky = 1'b0; end
      end else begin
        chk_rd = 1'b1;
        case (vid)
          12'd0:   exp_rd = {m_err[15:0], 5'b0, m_last, 7'b0, m_sticky};
          12'd1:   exp_rd = 32'd4;
          12'd2:   exp_rd = TOUT;
          default: exp_rd = 32'd0;
        endcase
      end
    end else if (mid >= 3'd4) begin
      exp_lat = 1;
      model_log(mid);
      if (!wr) begin chk_rd = 1'b1; exp_rd = 32'hFFFF_FFFF; end
    end else if (wr) begin
      exp_stb = 1;
      if (stall >= TOUT) begin exp_lat = 2 + TOUT; model_log(mid); end
      else exp_lat = 3 + stall;
    end else begin
      exp_lat = 2;
      chk_rd = 1'b1;
      exp_rd = so_model[mid[1:0]];
    end

    s0_address = {1'b0, mid, vid};
    s0_write = wr;
    s0_read = rd;
    s0_writedata = wd;
    lat = -1;
    nstb = 0;
    sc = -1;
    got_rd = '0;
    for (int c = 0; c < 64; c++) begin
      slot_wait = '0;
      if (sc >= 0 && c > sc && c <= sc + stall) slot_wait[mid[1:0]] = 1'b1;
      if (slot_strobe != 4'b0) begin
        nstb++;
        sc = c;
        check({tag, "_strobe"}, 32'(slot_strobe), 32'(4'b0001 << mid[1:0]));
        check({tag, "_svid"}, 32'(slot_vid), 32'(vid));
        check({tag, "_sin"}, slot_in, wd);
      end
      if (!s0_waitrequest) begin
        lat = c;
        got_rd = s0_readdata;
        s0_write = 1'b0;
        s0_read = 1'b0;
        tick;
        break;
      end
      tick;
    end
    s0_write = 1'b0;
    s0_read = 1'b0;
    slot_wait = '0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_nstb"}, nstb, exp_stb);
    if (chk_rd) check({tag, "_rdata"}, got_rd, exp_rd);
    check({tag, "_wr_high"}, 32'(s0_waitrequest), 32'd1);
    check({tag, "_shadow_vid"}, 32'(slot_vid), 32'(vid));
    check({tag, "_shadow_in"}, slot_in, wd);
  endtask

  initial begin
    reset = 1'b1;
    s0_address = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
    slot_wait = '0;
    slot_out = '0;
    for (int k = 0; k < 4; k++) so_model[k] = '0;
    m_err = 0; m_last = '0; m_sticky = 1'b0;
    tick; tick;
    reset = 1'b0;

    check("rst_waitreq", 32'(s0_waitrequest), 32'd1);
    check("rst_rdata", s0_readdata, 32'd0);
    check("rst_strobe", 32'(slot_strobe), 32'd0);
    check("rst_vid", 32'(slot_vid), 32'd0);
    check("rst_in", slot_in, 32'd0);
    run_txn("stat0_init", 1'b0, 1'b1, 3'd7, 12'd0, 32'd0, 0);

    load_slots(1'b1);
    run_txn("wr_stall", 1'b1, 1'b0, 3'd1, 12'd5, 32'h1234, 3);
    so_model[2] = 32'h0000_CAFE;
    load_slots(1'b0);
    run_txn("rd_slot2", 1'b0, 1'b1, 3'd2, 12'd16, 32'd0, 0);
    run_txn("rd_unpop", 1'b0, 1'b1, 3'd5, 12'd3, 32'd0, 0);
    run_txn("stat_err1", 1'b0, 1'b1, 3'd7, 12'd0, 32'd0, 0);
    run_txn("wr_timeout", 1'b1, 1'b0, 3'd0, 12'd7, 32'hDEAD_BEEF, 1000);
    run_txn("stat_err2", 1'b0, 1'b1, 3'd7, 12'd0, 32'd0, 0);
    run_txn("stat_clr", 1'b1, 1'b0, 3'd7, 12'd0, 32'h5555_0000, 0);
    run_txn("stat_err3", 1'b0, 1'b1, 3'd7, 12'd0, 32'd0, 0);
    run_txn("stat_nslots", 1'b0, 1'b1, 3'd7, 12'd1, 32'd0, 0);
    run_txn("stat_tout", 1'b0, 1'b1, 3'd7, 12'd2, 32'd0, 0);
    run_txn("stat_other", 1'b0, 1'b1, 3'd7, 12'd9, 32'd0, 0);
    run_txn("wr_unpop", 1'b1, 1'b1, 3'd6, 12'd1, 32'h77, 0);

    // Reset while the bridge is waiting on a busy slot.
    s0_address = {1'b0, 3'd0, 12'd9};
    s0_writedata = 32'hABCD;
    s0_write = 1'b1;
    tick;
    check("rstw_strobe", 32'(slot_strobe), 32'd1);
    slot_wait = 4'b0001;
    tick; tick;
    reset = 1'b1;
    s0_write = 1'b0;
    tick;
    check("rstw_strobe_low", 32'(slot_strobe), 32'd0);
    check("rstw_waitreq", 32'(s0_waitrequest), 32'd1);
    reset = 1'b0;
    slot_wait = '0;
    m_err = 0; m_last = '0; m_sticky = 1'b0;
    run_txn("rstw_rd3", 1'b0, 1'b1, 3'd3, 12'd44, 32'd0, 0);
    run_txn("rstw_stat", 1'b0, 1'b1, 3'd7, 12'd0, 32'd0, 0);

    run_txn("b2b_0", 1'b1, 1'b0, 3'd0, 12'd1, 32'h1111, 1);
    run_txn("b2b_1", 1'b1, 1'b0, 3'd1, 12'd2, 32'h2222, 0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  mid;
      logic [11:0] vid;
      bit          wr, rd;
      int          stall;
      load_slots(1'b1);
      mid = 3'($urandom_range(0, 7));
      vid = (mid == 3'd7) ? 12'($urandom_range(0, 3)) : 12'($urandom);
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      case ($urandom_range(0, 9))
        0:       stall = TOUT;
        1:       stall = TOUT - 1;
        2:       stall = 40;
        default: stall = int'($urandom_range(0, 4));
      endcase
      run_txn($sformatf("rnd%0d", i), wr, rd, mid, vid, $urandom, stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avmm_slot_bridge.md
# avmm_slot_bridge

Parametrised Avalon-MM slave front end for the FPGA program-logic shell: decodes each host access into a slot (module) id and variable id, drives a single-cycle request strobe into the selected slot, waits on that slot's busy flag, and then completes the bus transaction. It supersedes the fixed single-slot combinational demux. It adds the following:
- a configurable slot count and widths;
- an explicit transaction FSM;
- a per-access timeout;
- an error/status register bank at a reserved slot id.

## Interface
Parameters:
- N_SLOTS, 4: number of populated slots; must satisfy N_SLOTS ≤ 2^MID_W − 1.
- MID_W, 3: slot id width, taken from s0_address[MID_W+VID_W-1:VID_W].
- VID_W, 12: variable id width, taken from s0_address[VID_W-1:0].
- DATA_W, 32: data width.
- TIMEOUT, 1024: maximum number of cycles spent in WAIT; must be ≥ 1.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- s0_address  in  16  word address, split into {mid, vid}.
- s0_read  in  1  Avalon read request.
- s0_write  in  1  Avalon write request.
- s0_writedata  in  DATA_W  write data.
- s0_readdata  out  DATA_W  registered read data.
- s0_waitrequest  out  1  registered; low for exactly one cycle per transaction.
- slot_strobe  out  N_SLOTS  one-hot request pulse, one cycle wide.
- slot_vid  out  VID_W  latched variable id.
- slot_in  out  DATA_W  latched write data.
- slot_out  in  N_SLOTS*DATA_W  per-slot read data; slot k occupies [k*DATA_W +: DATA_W].
- slot_wait  in  N_SLOTS  per-slot busy flag.

## Operation
FSM states are IDLE, ISSUE, WAIT, SAMPLE, RESP.

- **IDLE**
  - On s0_write or s0_read, latch mid, vid and writedata.
  - If both s0_write and s0_read are asserted, the write wins.
  - Next state:
    - mid < N_SLOTS and write → ISSUE.
    - mid < N_SLOTS and read → SAMPLE.
    - mid == 2^MID_W−1 (status slot) → RESP.
    - Any other mid (unpopulated) → RESP, and log an error.
- **ISSUE**
  - slot_strobe[mid] = 1 for this cycle only.
  - slot_vid and slot_in hold the latched values.
  - Next state is WAIT.
- **WAIT**
  - If slot_wait[mid] == 0 → RESP.
  - Else increment the timeout counter; when it reaches TIMEOUT−1 → RESP and log an error.
- **SAMPLE**
  - readdata register ← slot_out[mid].
  - Next state is RESP.
- **RESP**
  - s0_waitrequest = 0 for this cycle; readdata is valid.
  - Next state is IDLE.
- **Error read data:** a read that hits an unpopulated slot returns all-ones. A write to an unpopulated slot is dropped.
- **Error logging** (on each logged error):
  - err_count (16 bits) increments and saturates at 0xFFFF.
  - last_err_mid ← mid.
  - sticky_err ← 1.
- **Status slot reads:**
  - vid 0 = {err_count[15:0], last_err_mid zero-extended to 8 bits, 7'b0, sticky_err}.
  - vid 1 = N_SLOTS.
  - vid 2 = TIMEOUT.
  - Any other vid = 0.
- **Status slot writes:** a write to vid 0 clears err_count, last_err_mid and sticky_err, regardless of data. Writes to any other vid are ignored.
- **Shadowing:** slot_vid and slot_in hold their values from the latch in IDLE until the next transaction is accepted.

## Timing
- **Reset values:**
  - s0_waitrequest = 1, s0_readdata = 0, slot_strobe = 0, slot_vid = 0, slot_in = 0.
  - State = IDLE, counters and error registers = 0.
- **Latency:** cycle 0 is the cycle the request is seen in IDLE.
  - Read: s0_waitrequest low in cycle 2.
  - Write: s0_waitrequest low in cycle 3 at minimum, plus one cycle per WAIT cycle with slot_wait high.
  - Status-slot or unpopulated-slot access: s0_waitrequest low in cycle 1.
- **Handshake:**
  - The master holds its request while s0_waitrequest is high.
  - Request inputs are ignored outside IDLE.
  - A request still asserted in the cycle after RESP is treated as a new transaction.
- **Strobe and busy:**
  - Exactly one strobe is issued per accepted write.
  - slot_wait is first examined in the cycle after the strobe, so a slot must raise wait no later than that cycle.
- **Timeout:** at most TIMEOUT WAIT cycles; the counter clears on entry to ISSUE.
- **Reset mid-operation:** in the next cycle, return to IDLE with strobes low and s0_waitrequest high. The in-flight transaction is abandoned without a response.

## Structure
- Package avmm_bridge_pkg holds:
  - the FSM state encoding;
  - the status vid constants (STAT_ERR = 0, STAT_NSLOTS = 1, STAT_TIMEOUT = 2);
  - the error read-data constant.
- One sub-module, avmm_slot_select: a combinational N_SLOTS-way read mux with a range check that yields the valid bit. All sequential logic stays in the top level.

## Test plan
1. **Write with stall:** write slot 1, vid 5, data 0x1234; bench holds slot_wait[1] high for 3 cycles after the strobe → single pulse on slot_strobe[1] with slot_vid = 5 and slot_in = 0x1234; s0_waitrequest low for one cycle, in cycle 6.
2. **Read:** read slot 2, vid 16, with slot_out[2] = 0xCAFE → s0_readdata = 0x0000CAFE with s0_waitrequest low in cycle 2; no strobe issued.
3. **Unpopulated slot:** read mid 5 with N_SLOTS = 4 → returns 0xFFFFFFFF; status vid 0 then reads 0x00010501.
4. **Timeout:** TIMEOUT = 16, slot_wait[0] stuck high, write slot 0 → completes after 16 WAIT cycles; sticky_err = 1. A write to status vid 0 then leads to a status read of 0.
5. **Reset during WAIT:** assert reset while in WAIT → next cycle shows strobes 0 and s0_waitrequest 1; a following read of slot 3 completes normally in 2 cycles.
6. **Back-to-back writes:** two writes to slots 0 and 1 with no idle cycle between them → second strobe appears only after the first RESP; each transaction gets exactly one low cycle of s0_waitrequest.
